// File: rtl/shift_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_pkg
//  Brief    : Mode encodings and sizing helper shared by the universal
//             shift register and its frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_ROR  = 2'b11;

    // Counter width for a frame of w shifts; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage : shift_reg_pkg
`default_nettype wire

// File: rtl/shift_frame_counter.sv
`default_nettype none
// ============================================================================
//  Module   : shift_frame_counter
//  Brief    : Counts shift steps modulo WIDTH and pulses done for one cycle
//             after the WIDTH-th step of a frame.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_frame_counter
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          step,
    output logic [cnt_width(WIDTH)-1:0]   count,
    output logic                          done
);

    localparam int             CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0]  c_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;
    logic          r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (clear) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (step) begin
            if (r_count == c_LAST) begin
                r_count <= '0;
                r_done  <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
                r_done  <= 1'b0;
            end
        end else begin
            // Idle cycles keep the count but never extend the pulse.
            r_done  <= 1'b0;
        end
    end

    assign count = r_count;
    assign done  = r_done;

endmodule : shift_frame_counter
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : univ_shift_reg
//  Brief    : Universal shift register with parallel load, shift right/left,
//             rotate right, serial I/O and shift-frame tracking.
//  Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          load,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              d_in,
    input  logic                          s_in_r,
    input  logic                          s_in_l,
    output logic [WIDTH-1:0]              q,
    output logic                          s_out_r,
    output logic                          s_out_l,
    output logic [cnt_width(WIDTH)-1:0]   shift_cnt,
    output logic                          frame_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shift_q;
    logic             w_shift;
    logic             w_clear;

    assign w_clear = enable & load;
    assign w_shift = enable & ~load & (mode != MODE_HOLD);

    always_comb begin
        w_shift_q = r_q;
        case (mode)
            MODE_SHR: w_shift_q = {s_in_r, r_q[WIDTH-1:1]};
            MODE_SHL: w_shift_q = {r_q[WIDTH-2:0], s_in_l};
            MODE_ROR: w_shift_q = {r_q[0], r_q[WIDTH-1:1]};
            default:  w_shift_q = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (enable) begin
            if (load) begin
                r_q <= d_in;
            end else begin
                r_q <= w_shift_q;
            end
        end
    end

    shift_frame_counter #(
        .WIDTH (WIDTH)
    ) u_frame_counter (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .step  (w_shift),
        .count (shift_cnt),
        .done  (frame_done)
    );

    assign q       = r_q;
    assign s_out_r = r_q[0];
    assign s_out_l = r_q[WIDTH-1];

endmodule : univ_shift_reg
`default_nettype wire

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 SHALL have parameter RESET_VAL, default 0 (WIDTH bits), value of q after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  1 = load/shift permitted; 0 = hold all state.
REQ-006 SHALL have port load  input  1  parallel-load request; priority over mode.
REQ-007 SHALL have port mode  input  2  00 hold, 01 shift right, 10 shift left, 11 rotate right.
REQ-008 SHALL have port d_in  input  WIDTH  parallel-load data.
REQ-009 SHALL have port s_in_r  input  1  serial bit entering q[WIDTH-1] on shift right.
REQ-010 SHALL have port s_in_l  input  1  serial bit entering q[0] on shift left.
REQ-011 SHALL have port q  output  WIDTH  register contents, registered.
REQ-012 SHALL have port s_out_r  output  1  equals q[0], combinational from q.
REQ-013 SHALL have port s_out_l  output  1  equals q[WIDTH-1], combinational from q.
REQ-014 SHALL have port shift_cnt  output  CW=max(1,$clog2(WIDTH))  shifts completed in current frame, 0..WIDTH-1, registered.
REQ-015 SHALL have port frame_done  output  1  registered one-cycle pulse marking WIDTH shifts completed.

Function
REQ-016 Per edge, priority SHALL be: reset > enable=0 (hold) > load > mode.
REQ-017 load=1 with enable=1: q <= d_in, shift_cnt <= 0, frame_done <= 0, regardless of mode.
REQ-018 mode 01: q <= {s_in_r, q[WIDTH-1:1]}; mode 10: q <= {q[WIDTH-2:0], s_in_l}; mode 11: q <= {q[0], q[WIDTH-1:1]}; mode 00: q unchanged.
REQ-019 A "shift cycle" is enable=1, load=0, mode!=00; only shift cycles advance shift_cnt.
REQ-020 On a shift cycle with shift_cnt < WIDTH-1: shift_cnt increments, frame_done <= 0.
REQ-021 On a shift cycle with shift_cnt = WIDTH-1: shift_cnt wraps to 0, frame_done <= 1 (visible the cycle after the WIDTH-th shift).
REQ-022 frame_done SHALL be 0 on every cycle not covered by REQ-021; it never stays high two cycles unless two consecutive edges both satisfy REQ-021 (impossible for WIDTH>=2).
REQ-023 Hold cycles (enable=0 or mode=00) SHALL retain q and shift_cnt and drive frame_done <= 0.
REQ-024 Direction changes between modes 01/10/11 mid-frame SHALL NOT clear shift_cnt.
REQ-025 Latency: q, shift_cnt, frame_done change one edge after the qualifying inputs; s_out_r/s_out_l follow q with zero latency.

Reset
REQ-026 reset=1 at an edge SHALL set q <= RESET_VAL, shift_cnt <= 0, frame_done <= 0, overriding enable, load and mode.
REQ-027 Reset mid-frame SHALL discard the partial count and SHALL NOT generate frame_done.

Structure
REQ-028 Package shift_reg_pkg SHALL hold mode encodings MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_ROR=2'b11.
REQ-029 Frame counting SHALL be a sub-module shift_frame_counter (inputs clk, reset, clear, step; outputs count, done), parameterised by WIDTH.
REQ-030 No latches; all registers in clk-edge processes with synchronous reset.

Verification (WIDTH=4, RESET_VAL=0)
REQ-031 Reset with d_in=1111, load=1, enable=1 -> q=0000, shift_cnt=0, frame_done=0.
REQ-032 load=1, mode=01, d_in=1011 -> q=1011, shift_cnt=0 (load wins over shift).
REQ-033 From q=1011, mode=01, s_in_r=1, 4 edges -> q=1101,1110,1111,1111; shift_cnt 1,2,3,0; frame_done=1 only after 4th edge.
REQ-034 From q=1000, mode=11, 4 edges -> q=0100,0010,0001,1000; frame_done pulse after 4th; mode=10, s_in_l=1 from 0000 -> 0001,0011.
REQ-035 Two shifts, enable=0 for 3 cycles, then two shifts -> q/shift_cnt frozen during hold, frame_done only after total 4th shift.
REQ-036 Reset asserted with shift_cnt=3 during mode=01 -> q=0000, shift_cnt=0, frame_done stays 0 next cycle.
